// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command scheduler: instruction field layout,
// opcodes and execution FSM states.
package gpu_pkg;

   localparam int unsigned OPC_HI  = 31;
   localparam int unsigned OPC_LO  = 28;
   localparam int unsigned COUNT_W = 16;

   localparam logic [3:0] OP_NOP         = 4'd0;
   localparam logic [3:0] OP_SET_COLOR   = 4'd1;
   localparam logic [3:0] OP_SET_ADDR    = 4'd2;
   localparam logic [3:0] OP_WRITE_PIXEL = 4'd3;
   localparam logic [3:0] OP_FILL        = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2
   } state_e;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous instruction FIFO with first-word fall-through read; a push
// into a full FIFO is still accepted when a pop happens in the same cycle.
module gpu_cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign o_full  = (count_q == DEPTH_C);
   assign o_empty = (count_q == '0);
   assign o_data  = mem_q[rd_ptr_q];
   assign pop_ok  = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || pop_ok);
   assign o_drop  = i_push && !push_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count marks them valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

endmodule

// File: rtl/gpu_command_scheduler.sv
// Buffers GPU instructions and executes them as framebuffer writes, sharing
// the single-port RAM with display reads that always win arbitration.
module gpu_command_scheduler
   import gpu_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FB_ADDR_W  = 15,
   parameter int unsigned COLOR_W    = 12
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [31:0]          i_instruction,
   input  logic                 i_instruction_ready,
   output logic                 o_fifo_full,
   output logic                 o_busy,
   output logic                 o_overflow,
   output logic                 o_illegal,
   input  logic                 i_disp_req,
   input  logic [FB_ADDR_W-1:0] i_disp_addr,
   output logic [COLOR_W-1:0]   o_color,
   output logic                 o_color_valid,
   output logic [FB_ADDR_W-1:0] o_mem_addr,
   output logic                 o_mem_we,
   output logic [COLOR_W-1:0]   o_mem_wdata,
   input  logic [COLOR_W-1:0]   i_mem_rdata
);

   logic [31:0]          fifo_data;
   logic                 fifo_empty;
   logic                 fifo_drop;
   logic                 pop;
   logic [3:0]           opcode;
   logic                 unused_bits;

   state_e               state_q, state_d;
   logic [COLOR_W-1:0]   cur_color_q, cur_color_d;
   logic [FB_ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [COUNT_W-1:0]   remaining_q, remaining_d;
   logic                 overflow_q, overflow_d;
   logic                 illegal_q, illegal_d;
   logic                 disp_req_q, disp_req_d;
   logic [COLOR_W-1:0]   color_q, color_d;
   logic                 color_valid_q, color_valid_d;

   gpu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_instruction_ready),
      .i_data  (i_instruction),
      .i_pop   (pop),
      .o_data  (fifo_data),
      .o_full  (o_fifo_full),
      .o_empty (fifo_empty),
      .o_drop  (fifo_drop)
   );

   assign opcode      = fifo_data[OPC_HI:OPC_LO];
   assign unused_bits = ^fifo_data[OPC_LO-1:COUNT_W];

   always_comb begin
      state_d       = state_q;
      cur_color_d   = cur_color_q;
      cur_addr_d    = cur_addr_q;
      remaining_d   = remaining_q;
      illegal_d     = illegal_q;
      pop           = 1'b0;
      overflow_d    = overflow_q | fifo_drop;
      disp_req_d    = i_disp_req;
      color_valid_d = disp_req_q;
      color_d       = disp_req_q ? i_mem_rdata : color_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               case (opcode)
                  OP_NOP:         ;
                  OP_SET_COLOR:   cur_color_d = fifo_data[COLOR_W-1:0];
                  OP_SET_ADDR:    cur_addr_d  = fifo_data[FB_ADDR_W-1:0];
                  OP_WRITE_PIXEL: state_d     = ST_WRITE;
                  OP_FILL: begin
                     if (fifo_data[COUNT_W-1:0] != '0) begin
                        state_d     = ST_FILL;
                        remaining_d = fifo_data[COUNT_W-1:0];
                     end
                  end
                  default:        illegal_d   = 1'b1;
               endcase
            end
         end
         ST_WRITE: begin
            if (!i_disp_req) begin
               cur_addr_d = cur_addr_q + 1'b1;
               state_d    = ST_IDLE;
            end
         end
         ST_FILL: begin
            // A display request only delays the pending write; nothing advances.
            if (!i_disp_req) begin
               cur_addr_d  = cur_addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == COUNT_W'(1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= ST_IDLE;
         cur_color_q   <= '0;
         cur_addr_q    <= '0;
         remaining_q   <= '0;
         overflow_q    <= 1'b0;
         illegal_q     <= 1'b0;
         disp_req_q    <= 1'b0;
         color_q       <= '0;
         color_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_color_q   <= cur_color_d;
         cur_addr_q    <= cur_addr_d;
         remaining_q   <= remaining_d;
         overflow_q    <= overflow_d;
         illegal_q     <= illegal_d;
         disp_req_q    <= disp_req_d;
         color_q       <= color_d;
         color_valid_q <= color_valid_d;
      end
   end

   always_comb begin
      o_mem_addr  = cur_addr_q;
      o_mem_we    = 1'b0;
      o_mem_wdata = cur_color_q;
      if (i_disp_req) begin
         o_mem_addr = i_disp_addr;
      end else if (state_q == ST_WRITE || state_q == ST_FILL) begin
         o_mem_we = 1'b1;
      end
   end

   assign o_busy        = !fifo_empty || (state_q != ST_IDLE);
   assign o_overflow    = overflow_q;
   assign o_illegal     = illegal_q;
   assign o_color       = color_q;
   assign o_color_valid = color_valid_q;

endmodule

// File: doc/gpu_command_scheduler.md
Name: gpu_command_scheduler

Overview:
Accepts 32-bit GPU instructions, buffers them in a small FIFO, and executes them as framebuffer writes. It arbitrates the single-port framebuffer RAM between the display read path and instruction writes, with display reads always taking priority. The block sits between the instruction source and the VGA signal generator, and supplies the 12-bit pixel colour that the generator consumes.

Parameters:
FIFO_DEPTH, 8, instruction FIFO entries (power of two, at least 2)
FB_ADDR_W, 15, framebuffer address width
COLOR_W, 12, pixel colour width (4:4:4 RGB)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_instruction  in  32  instruction word
i_instruction_ready  in  1  push strobe for i_instruction
o_fifo_full  out  1  FIFO holds FIFO_DEPTH entries
o_busy  out  1  FIFO non-empty or FSM not IDLE
o_overflow  out  1  sticky: a push was dropped
o_illegal  out  1  sticky: an undefined opcode was popped
i_disp_req  in  1  display read request this cycle
i_disp_addr  in  FB_ADDR_W  display read address
o_color  out  COLOR_W  display pixel colour
o_color_valid  out  1  o_color updated this cycle
o_mem_addr  out  FB_ADDR_W  RAM address
o_mem_we  out  1  RAM write enable
o_mem_wdata  out  COLOR_W  RAM write data
i_mem_rdata  in  COLOR_W  RAM read data, valid 1 cycle after address

Behaviour:
- Reset state:
  - FIFO empty; FSM in IDLE; cur_color=0; cur_addr=0; remaining=0.
  - o_overflow=0, o_illegal=0, o_color=0, o_color_valid=0, o_mem_we=0.
  - Reset mid-operation aborts the operation: no write is issued in the cycle after reset is asserted.
- Instruction format: opcode [31:28].
  - 0 NOP.
  - 1 SET_COLOR: cur_color <= [11:0].
  - 2 SET_ADDR: cur_addr <= [FB_ADDR_W-1:0].
  - 3 WRITE_PIXEL.
  - 4 FILL: count = [15:0].
  - 5..15 illegal: set o_illegal, otherwise treated as NOP.
- FIFO push rules:
  - A push when not full is accepted.
  - A push when full with a simultaneous pop is accepted.
  - A push when full without a pop is dropped and sets o_overflow.
- FSM states: IDLE, WRITE, FILL.
  - IDLE: if the FIFO is non-empty, pop one entry per cycle and decode it in the same cycle.
  - NOP, SET_COLOR, SET_ADDR, illegal opcodes and FILL with count 0 all complete in IDLE.
  - WRITE_PIXEL goes to WRITE.
  - FILL with count > 0 goes to FILL with remaining=count.
  - WRITE: if i_disp_req, stall. Otherwise write cur_color to cur_addr, set cur_addr+1, return to IDLE.
  - FILL: if i_disp_req, stall. Otherwise write, set cur_addr+1 and remaining-1. When remaining==1 at the write, return to IDLE.
  - No pop occurs while in WRITE or FILL.
- cur_addr increment wraps modulo 2^FB_ADDR_W.
- RAM mux (combinational):
  - i_disp_req=1: o_mem_addr=i_disp_addr, o_mem_we=0.
  - Else if in WRITE or FILL: o_mem_addr=cur_addr, o_mem_we=1, o_mem_wdata=cur_color.
  - Else: o_mem_addr=cur_addr, o_mem_we=0.
- Display read path:
  - disp_req_d is a registered copy of i_disp_req.
  - When disp_req_d=1, o_color <= i_mem_rdata.
  - o_color_valid <= disp_req_d.
  - Request-to-colour latency is 2 cycles; o_color holds its value between reads.
- o_busy is combinational.
- Writes are never lost to arbitration, only delayed.
- The display is never stalled.

Decomposition:
- Package gpu_pkg holds:
  - opcode localparams OP_NOP..OP_FILL;
  - field positions (OPC_HI=31, OPC_LO=28, COUNT_W=16);
  - FSM state encodings.
- Sub-module gpu_cmd_fifo: synchronous FIFO with push/pop, full/empty and simultaneous push+pop on full.

Test Plan:
- SET_COLOR 0xF00, SET_ADDR 5, WRITE_PIXEL with i_disp_req=0 -> exactly one cycle with o_mem_we=1, addr=5, wdata=0xF00; then o_busy=0 and cur_addr=6.
- SET_ADDR 0x7FFE, FILL 4 -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001 on 4 consecutive cycles.
- FILL 3 at addr 0x10 with i_disp_req=1 (addr 0x200) for 2 cycles after the first write -> during those cycles o_mem_addr=0x200, we=0; 3 writes total (0x10, 0x11, 0x12), with the last at least 2 cycles later than in the unstalled case.
- FILL 0x100, then 9 back-to-back pushes during the fill (FIFO_DEPTH=8) -> o_fifo_full=1 and o_overflow=1; only the first 8 pushed instructions execute, the 9th is dropped.
- After the first scenario, pulse i_disp_req with addr 5 (RAM model returns 0xF00) -> o_color=0xF00 and o_color_valid=1 exactly 2 cycles later, then o_color_valid=0.
- Opcode 0xF -> o_illegal=1 and no write. Then FILL 100 with reset asserted 10 cycles in -> no writes after reset, and all status outputs return to 0.
